perceptron_seq: RTL and testbench



---
 rtl/perceptron_seq.sv | 144 ++++++++++++++
 tb/tb_perceptron_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_seq.sv
// perceptron_seq
//   Sequential perceptron. A vector of N_INPUTS signed x/w pairs and a bias
//   are accepted over a valid/ready handshake. One multiply-accumulate is
//   performed per clock into a saturating accumulator. The step activation
//   is then applied, and the result is held until the downstream side
//   takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   x/w/bias valid
//   in_ready   block can accept a vector (registered)
//   x, w       packed signed vectors; element i at [i*DATA_W +: DATA_W]
//   bias       signed bias
//   out_valid  result valid (registered)
//   out_ready  downstream accepts the result
//   out        activation: 1 iff sum >= 0, qualified by out_valid
//   sum        saturated weighted sum plus bias
//   sat        some accumulate step of this result clamped
module perceptron_seq #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 4,
  parameter int BIAS_W   = 6,
  parameter int ACC_W    = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic        [N_INPUTS*DATA_W-1:0] x,
  input  logic        [N_INPUTS*DATA_W-1:0] w,
  input  logic signed [BIAS_W-1:0]          bias,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out,
  output logic signed [ACC_W-1:0]           sum,
  output logic                              sat
);

  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  // Accumulator limits, expressed at the ACC_W+1 working width.
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] x_r [N_INPUTS];
  logic signed [DATA_W-1:0] w_r [N_INPUTS];
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;
  logic                     sat_r;
  logic                     in_ready_r;
  logic                     out_valid_r;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]      t;

  function automatic logic is_clamped(input logic signed [ACC_W:0] v);
    return (v > ACC_MAX) || (v < ACC_MIN);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] v);
    if (v > ACC_MAX)
      return ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN)
      return ACC_MIN[ACC_W-1:0];
    else
      return v[ACC_W-1:0];
  endfunction

  // MAC datapath: one extra bit of headroom so overflow is detectable before clamping.
  always_comb begin
    prod = (2*DATA_W)'(x_r[idx]) * (2*DATA_W)'(w_r[idx]);
    t    = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
  end

  // Operand capture: sampled only on the accepting edge, so later input
  // changes cannot disturb a result in progress.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        x_r[i] <= $signed(x[i*DATA_W +: DATA_W]);
        w_r[i] <= $signed(w[i*DATA_W +: DATA_W]);
      end
    end
  end

  // Control FSM and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      acc         <= '0;
      idx         <= '0;
      sat_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc        <= ACC_W'(bias);
            idx        <= '0;
            sat_r      <= 1'b0;
            in_ready_r <= 1'b0;
            state      <= MAC;
          end
        end
        MAC: begin
          // Later steps continue from the clamped value, and the flag is sticky.
          acc <= sat_clamp(t);
          if (is_clamped(t))
            sat_r <= 1'b1;
          if (idx == LAST_IDX) begin
            idx         <= '0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = acc;
  assign sat       = sat_r;
  // Qualified by out_valid so that out reads 0 while the sum register is
  // still zero after reset.
  assign out       = out_valid_r & ~acc[ACC_W-1];

endmodule

// File: tb/tb_perceptron_seq.sv
// tb_perceptron_seq
//   Directed bench for perceptron_seq. Four instances are used:
//   u0 uses the default parameters, u1 uses ACC_W=8, u2 uses N_INPUTS=1 and
//   u3 uses N_INPUTS=8. The bench covers reset, sums, saturation,
//   back-pressure and a randomised parameter sweep against a reference model.
module tb_perceptron_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [3:0]        vld;
  logic              out_ready;
  logic [31:0]       xbus, wbus;
  logic signed [5:0] bias_b;

  logic [3:0]        rdy, ov, ob, st;
  logic signed [9:0] s0, s1, s2, s3;
  logic signed [7:0] s1_8;

  int checks = 0;
  int errors = 0;

  perceptron_seq u0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
    .x(xbus[15:0]), .w(wbus[15:0]), .bias(bias_b),
    .out_valid(ov[0]), .out_ready(out_ready), .out(ob[0]), .sum(s0), .sat(st[0]));

  perceptron_seq #(.ACC_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
    .x(xbus[15:0]), .w(wbus[15:0]), .bias(bias_b),
    .out_valid(ov[1]), .out_ready(out_ready), .out(ob[1]), .sum(s1_8), .sat(st[1]));

  perceptron_seq #(.N_INPUTS(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
    .x(xbus[3:0]), .w(wbus[3:0]), .bias(bias_b),
    .out_valid(ov[2]), .out_ready(out_ready), .out(ob[2]), .sum(s2), .sat(st[2]));

  perceptron_seq #(.N_INPUTS(8)) u3 (
    .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(rdy[3]),
    .x(xbus), .w(wbus), .bias(bias_b),
    .out_valid(ov[3]), .out_ready(out_ready), .out(ob[3]), .sum(s3), .sat(st[3]));

  assign s1 = {{2{s1_8[7]}}, s1_8};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    logic [31:0] v;
    v = '0;
    v[3:0]   = 4'(a);
    v[7:4]   = 4'(b);
    v[11:8]  = 4'(c);
    v[15:12] = 4'(d);
    return v;
  endfunction

  function automatic logic signed [9:0] sum_of(input int which);
    case (which)
      0: return s0;
      1: return s1;
      2: return s2;
      default: return s3;
    endcase
  endfunction

  // Saturating reference: step-by-step clamp at ACC_W bits.
  task automatic ref_model(input int n, input int accw, input logic [31:0] xv,
                           input logic [31:0] wv, input int b,
                           output int s, output logic sf);
    int mx, mn, acc, t;
    mx  = (1 << (accw - 1)) - 1;
    mn  = -(1 << (accw - 1));
    acc = b;
    sf  = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = acc + int'($signed(xv[i*4 +: 4])) * int'($signed(wv[i*4 +: 4]));
      if (t > mx) begin acc = mx; sf = 1'b1; end
      else if (t < mn) begin acc = mn; sf = 1'b1; end
      else acc = t;
    end
    s = acc;
  endtask

  // Present one vector to instance 'which' and wait for its result.
  // Returns the sampled outputs and the accept-to-valid latency in cycles.
  task automatic run_vec(input int which, input logic [31:0] xv, input logic [31:0] wv,
                         input logic signed [5:0] b, output logic signed [9:0] s,
                         output logic o, output logic sf, output int lat);
    int n;
    n = 0;
    while (!rdy[which] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    xbus = xv; wbus = wv; bias_b = b;
    vld[which] = 1'b1;
    @(posedge clk); #1;
    vld[which] = 1'b0;
    // Scramble the inputs right after acceptance; the result must not change.
    xbus = $urandom; wbus = $urandom; bias_b = 6'($urandom);
    lat = 0;
    while (!ov[which] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    s  = sum_of(which);
    o  = ob[which];
    sf = st[which];
  endtask

  initial begin
    logic signed [9:0] s;
    logic o, sf, msf;
    int lat, es;
    logic [31:0] xv, wv;
    int b;

    rst = 1'b1; vld = '0; out_ready = 1'b1; xbus = '0; wbus = '0; bias_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(rdy[0]), 32'd1);
    check_eq("rst_out_valid", 32'(ov[0]), 32'd0);
    check_eq("rst_sum", 32'(s0), 32'd0);
    check_eq("rst_out", 32'(ob[0]), 32'd0);
    check_eq("rst_sat", 32'(st[0]), 32'd0);
    rst = 1'b0;

    // Basic sum
    run_vec(0, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), -6'sd10, s, o, sf, lat);
    check_eq("basic_sum", 32'(s), 32'd0);
    check_eq("basic_out", 32'(o), 32'd1);
    check_eq("basic_sat", 32'(sf), 32'd0);
    check_eq("basic_lat", 32'(lat), 32'd4);
    run_vec(0, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), -6'sd11, s, o, sf, lat);
    check_eq("basic2_sum", 32'(s), -32'sd1);
    check_eq("basic2_out", 32'(o), 32'd0);

    // Mixed signs
    run_vec(0, pack4(-8, 7, -3, 5), pack4(7, -8, 2, -1), 6'sd31, s, o, sf, lat);
    check_eq("mixed_sum", 32'(s), -32'sd92);
    check_eq("mixed_out", 32'(o), 32'd0);
    check_eq("mixed_sat", 32'(sf), 32'd0);

    // Saturation with ACC_W = 8
    run_vec(1, pack4(-8, -8, -8, -8), pack4(7, 7, 7, 7), 6'sd0, s, o, sf, lat);
    check_eq("satneg_sum", 32'(s), -32'sd128);
    check_eq("satneg_out", 32'(o), 32'd0);
    check_eq("satneg_sat", 32'(sf), 32'd1);
    run_vec(1, pack4(7, 7, 7, 7), pack4(7, 7, 7, 7), 6'sd31, s, o, sf, lat);
    check_eq("satpos_sum", 32'(s), 32'd127);
    check_eq("satpos_out", 32'(o), 32'd1);
    check_eq("satpos_sat", 32'(sf), 32'd1);

    // Back-pressure: 1*2+2*2+3*2+4*2 + 5 = 25
    out_ready = 1'b0;
    run_vec(0, pack4(1, 2, 3, 4), pack4(2, 2, 2, 2), 6'sd5, s, o, sf, lat);
    check_eq("bp_sum", 32'(s), 32'd25);
    for (int i = 0; i < 10; i++) begin
      xbus = $urandom; wbus = $urandom; bias_b = 6'($urandom);
      vld[0] = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_hold", {29'd0, ov[0], rdy[0], ob[0]}, 32'b101);
      check_eq("bp_hold_sum", 32'(s0), 32'd25);
    end
    vld[0] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_valid", 32'(ov[0]), 32'd0);
    check_eq("bp_release_ready", 32'(rdy[0]), 32'd1);

    // Reset in the middle of a MAC sequence
    xbus = pack4(1, 1, 1, 1); wbus = pack4(1, 1, 1, 1); bias_b = 6'sd0;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_in_ready", 32'(rdy[0]), 32'd1);
    check_eq("midrst_out_valid", 32'(ov[0]), 32'd0);
    check_eq("midrst_sum", 32'(s0), 32'd0);
    check_eq("midrst_sat", 32'(st[0]), 32'd0);
    rst = 1'b0;
    begin
      logic stray;
      stray = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        stray = stray | ov[0];
      end
      check_eq("midrst_no_stray", 32'(stray), 32'd0);
    end

    // N_INPUTS = 1 and 8 directed
    run_vec(2, 32'h0000_000D, 32'h0000_0005, 6'sd2, s, o, sf, lat);
    check_eq("n1_sum", 32'(s), -32'sd13);
    check_eq("n1_lat", 32'(lat), 32'd1);
    run_vec(3, 32'h7777_7777, 32'h7777_7777, 6'sd31, s, o, sf, lat);
    check_eq("n8_sum", 32'(s), 32'd423);
    check_eq("n8_out", 32'(o), 32'd1);
    check_eq("n8_sat", 32'(sf), 32'd0);
    check_eq("n8_lat", 32'(lat), 32'd8);
    run_vec(3, 32'h8888_8888, 32'h8888_8888, 6'sd0, s, o, sf, lat);
    check_eq("n8sat_sum", 32'(s), 32'd511);
    check_eq("n8sat_sat", 32'(sf), 32'd1);

    // Randomised sweep against the reference model
    for (int k = 0; k < 1000; k++) begin
      int which, n;
      which = (k % 2 == 0) ? 2 : 3;
      n = (which == 2) ? 1 : 8;
      xv = $urandom; wv = $urandom;
      b = int'($signed(6'($urandom)));
      if (which == 2) begin xv[31:4] = '0; wv[31:4] = '0; end
      ref_model(n, 10, xv, wv, b, es, msf);
      run_vec(which, xv, wv, 6'(b), s, o, sf, lat);
      check_eq("sweep_sum", 32'(s), 32'(es));
      check_eq("sweep_out", 32'(o), 32'(es >= 0));
      check_eq("sweep_sat", 32'(sf), 32'(msf));
      check_eq("sweep_lat", 32'(lat), 32'(n));
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
